// File: rtl/dq_job_sequencer_pkg.sv
// Shared types and helpers for the dequant/quant job sequencer.
package dq_job_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } seq_state_e;

  localparam logic [1:0] ERR_NONE         = 2'b00;
  localparam logic [1:0] ERR_CFG          = 2'b01;
  localparam logic [1:0] ERR_EARLY_LAST   = 2'b10;
  localparam logic [1:0] ERR_MISSING_LAST = 2'b11;

  localparam int unsigned SAT_W   = 64;
  localparam int unsigned PERF_W  = 32;
  localparam int unsigned CFG_BW_W = 32;
  localparam int unsigned SCALE_W = 16;

  // Quantisation settings snapshotted at job start.
  typedef struct packed {
    logic [CFG_BW_W-1:0] bitwidth;
    logic [SCALE_W-1:0]  scale_fp;
    logic [SCALE_W-1:0]  inv_scale_fp;
  } dq_quant_cfg_t;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input int unsigned       width);
    logic [SAT_W-1:0] max_val;
    max_val = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
    return (value >= max_val) ? max_val : value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/dq_job_sequencer_beat.sv
// Handshake counter for one AXI-Stream direction, with last-flag checking
// against the expected beat count.
module dq_beat_counter
  import dq_job_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 valid,
  input  logic                 ready,
  input  logic                 last,
  input  logic [CNT_WIDTH-1:0] target,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 reached,
  output logic                 early_last,
  output logic                 missing_last
);

  logic                 hs;
  logic [CNT_WIDTH-1:0] count_inc;
  logic [CNT_WIDTH-1:0] count_nxt;

  assign hs        = valid && ready;
  assign count_inc = CNT_WIDTH'(sat_inc(SAT_W'(count), CNT_WIDTH));
  assign count_nxt = hs ? count_inc : count;

  // Flags look at the beat being accepted this cycle so the FSM can react on it.
  assign reached      = (count_nxt >= target);
  assign early_last   = hs && last && (count_inc < target);
  assign missing_last = hs && !last && (count_inc == target);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (hs) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/dq_job_sequencer.sv
// Job controller for the 16-lane dequant/quant datapath.
// Optional performance counters are built when DQ_SEQ_PERF_CNT_EN is defined.
module dq_job_sequencer
  import dq_job_sequencer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH                   = 32,
  parameter int unsigned MAX_BITWIDTH_QUANTIZED_DATA = 16,
  parameter int unsigned SETUP_CYCLES                = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cfg_start,
  input  logic [CNT_WIDTH-1:0] cfg_num_of_values,
  input  logic [31:0]          cfg_bitwidth,
  input  logic [15:0]          cfg_scale_fp,
  input  logic [15:0]          cfg_inv_scale_fp,
  output logic                 dp_activate,
  output logic [CNT_WIDTH-1:0] dp_num_of_values,
  output logic [31:0]          dp_bitwidth,
  output logic [15:0]          dp_scale_fp,
  output logic [15:0]          dp_inv_scale_fp,
  input  logic                 rcv_valid,
  input  logic                 rcv_ready,
  input  logic                 rcv_last,
  input  logic                 trm_valid,
  input  logic                 trm_ready,
  input  logic                 trm_last,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic [31:0]          cnt_setup,
  output logic [31:0]          cnt_dequant_flow,
  output logic [31:0]          cnt_quant_flow
);

  localparam int unsigned SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  seq_state_e           state_q, state_d;
  logic [SETUP_W-1:0]   setup_cnt_q, setup_cnt_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  dq_quant_cfg_t        cfg_q, cfg_d;
  logic                 busy_q, busy_d;
  logic                 act_q, act_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [1:0]           err_q, err_d;
  logic                 start_acc;

  logic                 counting;
  logic                 cfg_bad;
  logic                 rx_valid, tx_valid;
  logic [CNT_WIDTH-1:0] rx_cnt, tx_cnt;
  logic                 rx_reached, rx_early, rx_missing;
  logic                 tx_reached, tx_early, tx_missing;
  logic                 early_any, missing_any;
  logic                 cnt_unused;

  assign counting = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign rx_valid = rcv_valid && counting;
  assign tx_valid = trm_valid && counting;
  assign cfg_bad  = (cfg_q.bitwidth == 32'd0) ||
                    (cfg_q.bitwidth > 32'(MAX_BITWIDTH_QUANTIZED_DATA)) ||
                    (num_q == '0);

  dq_beat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rx_cnt (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (start_acc),
    .valid        (rx_valid),
    .ready        (rcv_ready),
    .last         (rcv_last),
    .target       (num_q),
    .count        (rx_cnt),
    .reached      (rx_reached),
    .early_last   (rx_early),
    .missing_last (rx_missing)
  );

  dq_beat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_tx_cnt (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (start_acc),
    .valid        (tx_valid),
    .ready        (trm_ready),
    .last         (trm_last),
    .target       (num_q),
    .count        (tx_cnt),
    .reached      (tx_reached),
    .early_last   (tx_early),
    .missing_last (tx_missing)
  );

  // Raw beat counts are kept for debug visibility; sequencing uses the flags.
  assign cnt_unused  = ^{rx_cnt, tx_cnt};
  assign early_any   = rx_early || tx_early;
  assign missing_any = rx_missing || tx_missing;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    num_d       = num_q;
    cfg_d       = cfg_q;
    done_d      = done_q;
    error_d     = error_q;
    err_d       = err_q;
    busy_d      = 1'b0;
    act_d       = 1'b0;
    start_acc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          start_acc          = 1'b1;
          state_d            = ST_CHECK;
          num_d              = cfg_num_of_values;
          cfg_d.bitwidth     = cfg_bitwidth;
          cfg_d.scale_fp     = cfg_scale_fp;
          cfg_d.inv_scale_fp = cfg_inv_scale_fp;
          done_d             = 1'b0;
          error_d            = 1'b0;
          err_d              = ERR_NONE;
        end
      end
      ST_CHECK: begin
        setup_cnt_d = '0;
        if (cfg_bad) begin
          state_d = ST_FIN;
          error_d = 1'b1;
          err_d   = ERR_CFG;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (setup_cnt_q == SETUP_W'(SETUP_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          setup_cnt_d = setup_cnt_q + SETUP_W'(1);
        end
      end
      ST_RUN: begin
        if (early_any) begin
          state_d = ST_FIN;
        end else if (rx_reached) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tx_early || tx_reached) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // First stream error wins; a missing last does not abort the job.
    if (counting && (err_q == ERR_NONE) && (early_any || missing_any)) begin
      error_d = 1'b1;
      err_d   = early_any ? ERR_EARLY_LAST : ERR_MISSING_LAST;
    end

    if (state_d == ST_FIN) begin
      done_d = !error_d;
    end

    busy_d = (state_d == ST_CHECK) || (state_d == ST_SETUP) ||
             (state_d == ST_RUN)   || (state_d == ST_DRAIN);
    act_d  = (state_d == ST_RUN)   || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= '0;
      num_q       <= '0;
      cfg_q       <= '0;
      busy_q      <= 1'b0;
      act_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      num_q       <= num_d;
      cfg_q       <= cfg_d;
      busy_q      <= busy_d;
      act_q       <= act_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_q       <= err_d;
    end
  end

  assign dp_activate      = act_q;
  assign dp_num_of_values = num_q;
  assign dp_bitwidth      = cfg_q.bitwidth;
  assign dp_scale_fp      = cfg_q.scale_fp;
  assign dp_inv_scale_fp  = cfg_q.inv_scale_fp;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign err_code         = err_q;

`ifdef DQ_SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] setup_q;
  logic [PERF_W-1:0] rx_run_q, rx_span_q, tx_run_q, tx_span_q;
  logic              rx_seen_q, tx_seen_q;
  logic              rx_hs, tx_hs, setup_phase;
  logic [PERF_W-1:0] rx_span, tx_span;

  assign rx_hs       = rx_valid && rcv_ready;
  assign tx_hs       = tx_valid && trm_ready;
  assign setup_phase = (state_q == ST_CHECK) || (state_q == ST_SETUP);
  // Span so far, including this cycle, measured from the first handshake.
  assign rx_span = rx_seen_q ? PERF_W'(sat_inc(SAT_W'(rx_run_q), PERF_W)) : PERF_W'(1);
  assign tx_span = tx_seen_q ? PERF_W'(sat_inc(SAT_W'(tx_run_q), PERF_W)) : PERF_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      setup_q   <= '0;
      rx_run_q  <= '0;
      rx_span_q <= '0;
      rx_seen_q <= 1'b0;
      tx_run_q  <= '0;
      tx_span_q <= '0;
      tx_seen_q <= 1'b0;
    end else if (start_acc) begin
      setup_q   <= '0;
      rx_run_q  <= '0;
      rx_span_q <= '0;
      rx_seen_q <= 1'b0;
      tx_run_q  <= '0;
      tx_span_q <= '0;
      tx_seen_q <= 1'b0;
    end else begin
      if (setup_phase) setup_q <= PERF_W'(sat_inc(SAT_W'(setup_q), PERF_W));
      if (rx_seen_q || rx_hs) rx_run_q <= rx_span;
      if (tx_seen_q || tx_hs) tx_run_q <= tx_span;
      if (rx_hs) begin
        rx_span_q <= rx_span;
        rx_seen_q <= 1'b1;
      end
      if (tx_hs) begin
        tx_span_q <= tx_span;
        tx_seen_q <= 1'b1;
      end
    end
  end

  assign cnt_setup        = setup_q;
  assign cnt_dequant_flow = rx_span_q;
  assign cnt_quant_flow   = tx_span_q;
`else
  assign cnt_setup        = '0;
  assign cnt_dequant_flow = '0;
  assign cnt_quant_flow   = '0;
`endif

endmodule

// File: tb/tb_dq_job_sequencer.sv
// Directed self-checking bench for dq_job_sequencer (SETUP_CYCLES=2).
module tb_dq_job_sequencer;

`ifdef DQ_SEQ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        cfg_start;
  logic [31:0] cfg_num_of_values;
  logic [31:0] cfg_bitwidth;
  logic [15:0] cfg_scale_fp;
  logic [15:0] cfg_inv_scale_fp;
  logic        dp_activate;
  logic [31:0] dp_num_of_values;
  logic [31:0] dp_bitwidth;
  logic [15:0] dp_scale_fp;
  logic [15:0] dp_inv_scale_fp;
  logic        rcv_valid, rcv_ready, rcv_last;
  logic        trm_valid, trm_ready, trm_last;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] cnt_setup, cnt_dequant_flow, cnt_quant_flow;

  int n_tests;
  int n_fail;

  dq_job_sequencer dut (
    .clk               (clk),
    .rstn              (rstn),
    .cfg_start         (cfg_start),
    .cfg_num_of_values (cfg_num_of_values),
    .cfg_bitwidth      (cfg_bitwidth),
    .cfg_scale_fp      (cfg_scale_fp),
    .cfg_inv_scale_fp  (cfg_inv_scale_fp),
    .dp_activate       (dp_activate),
    .dp_num_of_values  (dp_num_of_values),
    .dp_bitwidth       (dp_bitwidth),
    .dp_scale_fp       (dp_scale_fp),
    .dp_inv_scale_fp   (dp_inv_scale_fp),
    .rcv_valid         (rcv_valid),
    .rcv_ready         (rcv_ready),
    .rcv_last          (rcv_last),
    .trm_valid         (trm_valid),
    .trm_ready         (trm_ready),
    .trm_last          (trm_last),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .err_code          (err_code),
    .cnt_setup         (cnt_setup),
    .cnt_dequant_flow  (cnt_dequant_flow),
    .cnt_quant_flow    (cnt_quant_flow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic b, input logic a,
                            input logic d, input logic e, input logic [1:0] ec);
    chk({tag, ".busy"},     32'(busy),        32'(b));
    chk({tag, ".activate"}, 32'(dp_activate), 32'(a));
    chk({tag, ".done"},     32'(done),        32'(d));
    chk({tag, ".error"},    32'(error),       32'(e));
    chk({tag, ".err_code"}, 32'(err_code),    32'(ec));
  endtask

  task automatic chk_perf(input string tag, input logic [31:0] s,
                          input logic [31:0] dq, input logic [31:0] q);
    chk({tag, ".cnt_setup"},   cnt_setup,        PERF_EN ? s  : 32'd0);
    chk({tag, ".cnt_dequant"}, cnt_dequant_flow, PERF_EN ? dq : 32'd0);
    chk({tag, ".cnt_quant"},   cnt_quant_flow,   PERF_EN ? q  : 32'd0);
  endtask

  task automatic idle_streams();
    rcv_valid = 1'b0; rcv_ready = 1'b0; rcv_last = 1'b0;
    trm_valid = 1'b0; trm_ready = 1'b0; trm_last = 1'b0;
  endtask

  // Leaves the bench in the CHECK cycle.
  task automatic start_job(input logic [31:0] nv, input logic [31:0] bw,
                           input logic [15:0] sc, input logic [15:0] isc);
    cfg_num_of_values = nv;
    cfg_bitwidth      = bw;
    cfg_scale_fp      = sc;
    cfg_inv_scale_fp  = isc;
    cfg_start         = 1'b1;
    step();
    cfg_start         = 1'b0;
  endtask

  // From the CHECK cycle, activate must stay low for 3 cycles and then rise.
  task automatic wait_run(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, ".pre_run_act"}, 32'(dp_activate), 32'd0);
      step();
    end
    chk_status({tag, ".run_entry"}, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn = 1'b0;
    cfg_start = 1'b0;
    cfg_num_of_values = '0;
    cfg_bitwidth = '0;
    cfg_scale_fp = '0;
    cfg_inv_scale_fp = '0;
    idle_streams();
    repeat (2) step();
    chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("reset.dp_num", dp_num_of_values, 32'd0);
    chk("reset.dp_bw", dp_bitwidth, 32'd0);
    chk_perf("reset", 32'd0, 32'd0, 32'd0);
    rstn = 1'b1;
    step();
    chk_status("idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Nominal: 4 beats, transmit trails receive by one cycle.
    start_job(32'd4, 32'd8, 16'h3c00, 16'h4000);
    chk("nom.busy_rise", 32'(busy), 32'd1);
    chk("nom.dp_num", dp_num_of_values, 32'd4);
    chk("nom.dp_bw", dp_bitwidth, 32'd8);
    chk("nom.dp_scale", 32'(dp_scale_fp), 32'h3c00);
    chk("nom.dp_inv", 32'(dp_inv_scale_fp), 32'h4000);
    wait_run("nom");
    for (int i = 0; i < 5; i++) begin
      rcv_valid = (i < 4); rcv_ready = 1'b1; rcv_last = (i == 3);
      trm_valid = (i >= 1); trm_ready = 1'b1; trm_last = (i == 4);
      step();
      if (i < 4) chk_status("nom.run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    idle_streams();
    chk_status("nom.fin", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk_perf("nom", 32'd3, 32'd4, 32'd4);
    step();
    chk_status("nom.idle", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

    // Bad config: bitwidth above maximum, then zero beat count.
    start_job(32'd4, 32'd17, 16'h0001, 16'h0002);
    chk_status("badbw.check", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    chk_status("badbw.fin", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    chk_perf("badbw", 32'd1, 32'd0, 32'd0);
    step();
    chk_status("badbw.idle", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    start_job(32'd0, 32'd8, 16'h0001, 16'h0002);
    chk_status("badnv.check", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    chk_status("badnv.fin", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step();

    // Early last on receive beat 3 of 8.
    start_job(32'd8, 32'd8, 16'h0100, 16'h0200);
    wait_run("early");
    for (int i = 0; i < 3; i++) begin
      rcv_valid = 1'b1; rcv_ready = 1'b1; rcv_last = (i == 2);
      step();
      if (i < 2) chk_status("early.run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    idle_streams();
    chk_status("early.fin", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step();
    chk_status("early.idle", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);

    // Missing last on transmit: error flagged but job runs to completion.
    start_job(32'd2, 32'd8, 16'h0100, 16'h0200);
    wait_run("miss");
    for (int i = 0; i < 2; i++) begin
      rcv_valid = 1'b1; rcv_ready = 1'b1; rcv_last = (i == 1);
      trm_valid = 1'b1; trm_ready = 1'b1; trm_last = 1'b0;
      step();
      chk_status("miss.run", 1'b1, 1'b1, 1'b0, (i == 1), (i == 1) ? 2'd3 : 2'd0);
    end
    idle_streams();
    step();
    chk_status("miss.fin", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
    step();

    // Transmit backpressure: ready toggles 1010..., 6 beats.
    start_job(32'd6, 32'd4, 16'h1234, 16'h5678);
    wait_run("bp");
    for (int i = 0; i < 11; i++) begin
      rcv_valid = (i < 6); rcv_ready = 1'b1; rcv_last = (i == 5);
      trm_valid = 1'b1; trm_ready = (i % 2 == 0); trm_last = (i == 10);
      step();
      if (i < 10) chk_status("bp.run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    idle_streams();
    chk_status("bp.fin", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk_perf("bp", 32'd3, 32'd6, 32'd11);
    step();
    chk("bp.hold_num", dp_num_of_values, 32'd6);
    chk("bp.hold_bw", dp_bitwidth, 32'd4);
    chk("bp.hold_scale", 32'(dp_scale_fp), 32'h1234);
    chk("bp.hold_inv", 32'(dp_inv_scale_fp), 32'h5678);

    // Start while running is ignored; reset mid-job clears everything.
    start_job(32'd4, 32'd4, 16'h1111, 16'h2222);
    wait_run("ign");
    cfg_num_of_values = 32'd9;
    cfg_bitwidth      = 32'd3;
    cfg_start         = 1'b1;
    rcv_valid = 1'b1; rcv_ready = 1'b1; rcv_last = 1'b0;
    step();
    cfg_start = 1'b0;
    idle_streams();
    chk("ign.dp_num", dp_num_of_values, 32'd4);
    chk("ign.dp_bw", dp_bitwidth, 32'd4);
    chk_status("ign.run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk_status("rstmid", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("rstmid.dp_num", dp_num_of_values, 32'd0);
    chk("rstmid.dp_bw", dp_bitwidth, 32'd0);
    chk_perf("rstmid", 32'd0, 32'd0, 32'd0);
    step();
    rstn = 1'b1;
    step();
    chk_status("rstmid.idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Clean job afterwards at the largest legal bitwidth.
    start_job(32'd2, 32'd16, 16'h0aaa, 16'h0bbb);
    chk_status("clean.check", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    wait_run("clean");
    for (int i = 0; i < 3; i++) begin
      rcv_valid = (i < 2); rcv_ready = 1'b1; rcv_last = (i == 1);
      trm_valid = (i >= 1); trm_ready = 1'b1; trm_last = (i == 2);
      step();
      if (i < 2) chk_status("clean.run", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    idle_streams();
    chk_status("clean.fin", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    chk_perf("clean", 32'd3, 32'd2, 32'd2);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dq_job_sequencer.md
Name: dq_job_sequencer

Overview:
- Job-level controller for the 16-lane dequant/quant datapath with its accelerator FIFO.
- Takes one start pulse plus config from the AXI-Lite register file and validates the config.
- Snapshots the config into stable datapath control, asserts activate for the job, and counts beats on the DMA receive and transmit streams.
- Reports done/error status and per-job cycle counters back to AXI-Lite.

Parameters:
- CNT_WIDTH, 32: width of beat and cycle counters, and of num_of_values.
- MAX_BITWIDTH_QUANTIZED_DATA, 16: largest legal cfg_bitwidth.
- SETUP_CYCLES, 2: cycles activate is held low between jobs, so the FIFO (reset by rstn && activate) clears. Minimum 1.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cfg_start  in  1  single-cycle job start request
- cfg_num_of_values  in  CNT_WIDTH  beats expected per stream; each beat is 16 lanes
- cfg_bitwidth  in  32  quantized bitwidth
- cfg_scale_fp  in  16  dequant scale
- cfg_inv_scale_fp  in  16  quant inverse scale
- dp_activate  out  1  datapath/FIFO enable
- dp_num_of_values  out  CNT_WIDTH  latched config
- dp_bitwidth  out  32  latched config
- dp_scale_fp  out  16  latched config
- dp_inv_scale_fp  out  16  latched config
- rcv_valid, rcv_ready, rcv_last  in  1 each  DMA→block stream monitor
- trm_valid, trm_ready, trm_last  in  1 each  block→DMA stream monitor
- busy  out  1  job in progress
- done  out  1  sticky; cleared by next accepted cfg_start
- error  out  1  sticky; cleared by next accepted cfg_start
- err_code  out  2  00 none, 01 bad config, 10 early last, 11 missing last
- cnt_setup  out  32  performance counter
- cnt_dequant_flow  out  32  performance counter
- cnt_quant_flow  out  32  performance counter

Behaviour:
- Reset values: every output 0; FSM in IDLE.
- rstn asserted mid-job: all state discarded immediately; no done is reported.
- FSM states: IDLE, CHECK, SETUP, RUN, DRAIN, FIN.
- IDLE → CHECK on cfg_start.
  - All cfg_* latched into dp_* that cycle.
  - done, error and err_code cleared.
  - busy rises the next cycle.
- cfg_start while busy is ignored; no state change.
- CHECK, 1 cycle. If cfg_bitwidth==0, cfg_bitwidth>MAX_BITWIDTH_QUANTIZED_DATA or cfg_num_of_values==0: err_code=01, error=1, go to FIN. Otherwise go to SETUP.
- SETUP: dp_activate=0 for SETUP_CYCLES cycles, then RUN.
- RUN: dp_activate=1.
  - rx_cnt increments on rcv_valid&&rcv_ready.
  - tx_cnt increments on trm_valid&&trm_ready.
  - A handshake carrying rcv_last or trm_last with its counter +1 < num_of_values: err_code=10, error=1, go to FIN.
  - A counter reaching num_of_values without last on the final beat: err_code=11, error=1, but the job completes normally.
  - When rx_cnt==num_of_values, go to DRAIN.
- DRAIN: wait for tx_cnt==num_of_values, then FIN. A transmit handshake in the same cycle as the final receive beat is counted.
- FIN, 1 cycle: dp_activate=0, busy=0; done=1 if error==0. Return to IDLE.
- Latency: start → first dp_activate=1 is 2+SETUP_CYCLES cycles.
- Counters saturate at all-ones and never wrap. The first error code wins; later errors do not overwrite it.
- dp_* outputs hold their values after the job until the next accepted start.

Optional Feature:
- Macro: DQ_SEQ_PERF_CNT_EN.
- Defined:
  - cnt_setup counts CHECK+SETUP cycles.
  - cnt_dequant_flow counts cycles from the first receive handshake to the last receive handshake, inclusive.
  - cnt_quant_flow counts cycles from the first transmit handshake to the last transmit handshake, inclusive.
  - All three clear on an accepted start, are 32-bit and saturating.
- Undefined: all three outputs are tied to 0 and no counter flops are built.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - err_code constants (ERR_NONE, ERR_CFG, ERR_EARLY_LAST, ERR_MISSING_LAST).
  - The saturating-increment function.
- One sub-module: dq_beat_counter.
  - Ports: clk, rstn, clr, valid, ready, last, target.
  - Outputs: count, reached, early_last, missing_last.
  - Instantiated twice, once for the receive stream and once for the transmit stream.

Test Plan:
- Nominal job: num_of_values=4, bitwidth=8, rcv/trm 4 beats each with last on the 4th → done=1 after the final transmit beat plus 1 cycle; error=0; dp_activate high only in RUN/DRAIN.
- Bad config: bitwidth=17 → err_code=01, error=1 at start+2 cycles; dp_activate never rises. Repeat with num_of_values=0 → same result.
- Early last: num_of_values=8, rcv_last on beat 3 → err_code=10, dp_activate=0 the following cycle, done=0.
- Missing last: num_of_values=2, no trm_last → err_code=11, job still reaches FIN.
- Backpressure: trm_ready toggling 1010… with num_of_values=6 → FSM stays in DRAIN until tx_cnt=6. With DQ_SEQ_PERF_CNT_EN, cnt_quant_flow equals the measured first-to-last transmit span.
- cfg_start pulse during RUN ignored; rstn pulse in RUN → all outputs 0 immediately; a new start afterwards runs clean.
